// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register for a 5-stage RV32I
//   pipeline. Holds the fetch PC, selects sequential or redirected next PC,
//   runs a req/ready handshake with instruction memory and presents the
//   fetched instruction to decode.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous reset, active-low
//   StallF      hold PCF (hazard unit)
//   StallD      hold IF/ID register (hazard unit)
//   FlushD      clear IF/ID register (hazard unit)
//   PcSrcE      taken branch/jump resolved in Execute
//   PCTargetE   redirect target from Execute
//   imem_req    fetch request valid
//   imem_addr   fetch address (= PCF)
//   imem_rdata  instruction word, valid when imem_req & imem_ready
//   imem_ready  memory accepts/returns this cycle
//   PCF         current fetch PC
//   InstrD      instruction to decode
//   PCD         PC of InstrD
//   PCPlus4D    PCD + 4
//   ValidD      InstrD is a real fetched instruction
//   FetchWaitF  request outstanding but memory not ready
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PcSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchWaitF
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_req;
    logic        w_done;
    logic [31:0] w_pc_plus4;

    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    // A redirect kills any response arriving in the same cycle.
    assign w_done     = w_req & imem_ready & ~PcSrcE;
    // 32-bit adder wraps naturally at the top of the address space.
    assign w_pc_plus4 = r_pc + 32'd4;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                // A stalled completion stays in FETCH and re-requests the same PC.
                if (PcSrcE || imem_ready) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // FSM output logic
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_BOOT:  w_req = 1'b0;
            ST_FETCH: w_req = 1'b1;
            ST_WAIT:  w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    // Fetch PC: reset, redirect, stall, advance, hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (PcSrcE) begin
            r_pc <= PCTargetE;
        end else if (StallF) begin
            r_pc <= r_pc;
        end else if (w_done) begin
            r_pc <= w_pc_plus4;
        end else begin
            r_pc <= r_pc;
        end
    end

    // IF/ID pipeline register: reset, flush, stall, load, bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'h0000_0000;
            r_pc_plus4_d <= 32'h0000_0000;
            r_valid_d    <= 1'b0;
        end else if (FlushD) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'h0000_0000;
            r_pc_plus4_d <= 32'h0000_0000;
            r_valid_d    <= 1'b0;
        end else if (StallD) begin
            r_instr_d    <= r_instr_d;
            r_pc_d       <= r_pc_d;
            r_pc_plus4_d <= r_pc_plus4_d;
            r_valid_d    <= r_valid_d;
        end else if (w_done && !StallF) begin
            r_instr_d    <= imem_rdata;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end else begin
            // Bubble: PCD/PCPlus4D keep their last values.
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= r_pc_d;
            r_pc_plus4_d <= r_pc_plus4_d;
            r_valid_d    <= 1'b0;
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign FetchWaitF = w_req & ~imem_ready;
    assign PCF        = r_pc;
    assign InstrD     = r_instr_d;
    assign PCD        = r_pc_d;
    assign PCPlus4D   = r_pc_plus4_d;
    assign ValidD     = r_valid_d;

endmodule
